// File: rtl/mem_refill_arbiter_pkg.sv
// mem_refill_arbiter_pkg
//   Shared definitions for the refill arbiter: FSM state encoding, one-hot
//   owner codes and the burst-length derivation used by the beat counters.
package mem_refill_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_REQ0 = 2'b01;
  localparam logic [1:0] OWN_REQ1 = 2'b10;

  // Beats per burst for a given log2 burst length.
  function automatic int unsigned burst_beats(input int unsigned len_width);
    return 32'd1 << len_width;
  endfunction

endpackage

// File: rtl/mem_refill_arbiter_counter.sv
// arb_burst_counter
//   WIDTH-bit beat counter, wraps modulo 2**WIDTH.
//   Ports:
//     clk     clock
//     rst     synchronous active-high reset
//     clr_i   synchronous clear (wins over inc_i)
//     inc_i   count one beat
//     last_o  current count is the final beat of a burst
module arb_burst_counter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam logic [WIDTH-1:0] LAST_BEAT = WIDTH'(burst_beats(WIDTH) - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST_BEAT);

endmodule

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter
//   Shares one memory refill channel between a D-cache (req0) and an
//   I-cache (req1). The channel is locked to one owner for a whole burst of
//   2**BURST_LEN_WIDTH address beats and the same number of data beats;
//   returned data is routed to the owner only. All channels are valid/busy
//   point-to-point: a beat moves when valid && !busy.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     req{0,1}_addr_{valid,busy,data}   requester address channels
//     req{0,1}_data_{valid,busy,data}   refill data toward requesters
//     mem_addr_{valid,busy,data}    address channel toward memory
//     mem_data_{valid,busy,data}    data channel from memory
//     arb_owner                     one-hot owner, 00 when idle
//   Build option:
//     MEM_ARB_ROUND_ROBIN_EN  alternate priority between requesters at each
//                             burst end; otherwise req0 always wins ties.
module mem_refill_arbiter
  import mem_refill_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned BURST_LEN_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_addr_valid,
  output logic                  req0_addr_busy,
  input  logic [ADDR_WIDTH-1:0] req0_addr_data,
  output logic                  req0_data_valid,
  input  logic                  req0_data_busy,
  output logic [DATA_WIDTH-1:0] req0_data_data,
  input  logic                  req1_addr_valid,
  output logic                  req1_addr_busy,
  input  logic [ADDR_WIDTH-1:0] req1_addr_data,
  output logic                  req1_data_valid,
  input  logic                  req1_data_busy,
  output logic [DATA_WIDTH-1:0] req1_data_data,
  output logic                  mem_addr_valid,
  input  logic                  mem_addr_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr_data,
  input  logic                  mem_data_valid,
  output logic                  mem_data_busy,
  input  logic [DATA_WIDTH-1:0] mem_data_data,
  output logic [1:0]            arb_owner
);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic       addr_done_q, addr_done_d;
  logic [1:0] grant;

  logic own0, own1;
  logic own_addr_valid, own_data_busy;
  logic addr_xfer, data_xfer, addr_last, data_last, burst_end;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_q = 1 favours req1 on a tie.
  logic rr_q, rr_d;

  always_comb begin
    if (req0_addr_valid && req1_addr_valid) begin
      grant = rr_q ? OWN_REQ1 : OWN_REQ0;
    end else begin
      grant = req0_addr_valid ? OWN_REQ0 : OWN_REQ1;
    end
  end
`else
  assign grant = req0_addr_valid ? OWN_REQ0 : OWN_REQ1;
`endif

  assign own0 = (state_q == ST_BURST) && (owner_q == OWN_REQ0);
  assign own1 = (state_q == ST_BURST) && (owner_q == OWN_REQ1);

  assign own_addr_valid = (own0 && req0_addr_valid) || (own1 && req1_addr_valid);
  assign own_data_busy  = (own0 && req0_data_busy)  || (own1 && req1_data_busy);

  // Once all address beats of the burst are sent, further owner beats are
  // held off until the burst closes.
  assign mem_addr_valid = own_addr_valid && !addr_done_q;
  assign mem_addr_data  = own0 ? req0_addr_data : (own1 ? req1_addr_data : '0);
  assign req0_addr_busy = own0 ? (mem_addr_busy || addr_done_q) : 1'b1;
  assign req1_addr_busy = own1 ? (mem_addr_busy || addr_done_q) : 1'b1;

  // Without an owner, memory data is stalled rather than dropped.
  assign mem_data_busy   = (own0 || own1) ? own_data_busy : 1'b1;
  assign req0_data_valid = own0 && mem_data_valid;
  assign req1_data_valid = own1 && mem_data_valid;
  assign req0_data_data  = own0 ? mem_data_data : '0;
  assign req1_data_data  = own1 ? mem_data_data : '0;

  assign arb_owner = owner_q;

  assign addr_xfer = mem_addr_valid && !mem_addr_busy;
  assign data_xfer = (own0 || own1) && mem_data_valid && !own_data_busy;
  assign burst_end = data_xfer && data_last;

  arb_burst_counter #(.WIDTH(BURST_LEN_WIDTH)) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (burst_end),
    .inc_i  (addr_xfer),
    .last_o (addr_last)
  );

  arb_burst_counter #(.WIDTH(BURST_LEN_WIDTH)) u_data_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (burst_end),
    .inc_i  (data_xfer),
    .last_o (data_last)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_done_d = addr_done_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d        = rr_q;
`endif
    if (state_q == ST_IDLE) begin
      if (req0_addr_valid || req1_addr_valid) begin
        state_d = ST_BURST;
        owner_d = grant;
      end
    end else begin
      if (addr_xfer && addr_last) begin
        addr_done_d = 1'b1;
      end
      if (burst_end) begin
        state_d     = ST_IDLE;
        owner_d     = OWN_NONE;
        addr_done_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_d        = (owner_q == OWN_REQ0);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      addr_done_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_done_q <= addr_done_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares one memory refill channel between two cache requesters: req0 (D-cache, default priority) and req1 (I-cache).
- Each requester issues a burst of 2**BURST_LEN_WIDTH address beats and receives the same number of data beats.
- The arbiter locks the channel to one owner for the whole burst and routes returned data back to that owner only.
- Sits between the cache load ports and the external memory p2p channel.
- All channels use valid/busy p2p: a beat transfers when valid && !busy.

Parameters:
ADDR_WIDTH  32  refill address width
DATA_WIDTH  64  refill data beat width
BURST_LEN_WIDTH  4  log2 of beats per burst (16 beats = one 128-byte line)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0_addr_valid  in  1  req0 address beat valid
req0_addr_busy  out  1  arbiter cannot accept req0 address
req0_addr_data  in  ADDR_WIDTH  req0 address
req0_data_valid  out  1  refill data valid toward req0
req0_data_busy  in  1  req0 stalls data
req0_data_data  out  DATA_WIDTH  refill data to req0
req1_addr_valid, req1_addr_busy, req1_addr_data, req1_data_valid, req1_data_busy, req1_data_data  as req0, for req1
mem_addr_valid  out  1  address beat toward memory
mem_addr_busy  in  1  memory stalls address
mem_addr_data  out  ADDR_WIDTH  forwarded address
mem_data_valid  in  1  memory data valid
mem_data_busy  out  1  arbiter stalls memory data
mem_data_data  in  DATA_WIDTH  memory data
arb_owner  out  2  one-hot current owner; 00 when idle

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Registered state: state (IDLE, BURST), owner, addr_cnt, addr_done, data_cnt, and the rr pointer (feature only).
- All outputs are combinational decodes of the registered state plus the current inputs.
- Reset (including mid-burst): state=IDLE, owner=00, counters=0, addr_done=0, rr pointer favours req0.
  - Resulting outputs: all *_valid=0, req*_addr_busy=1, mem_data_busy=1, all data outputs=0.
- IDLE:
  - req*_addr_busy=1 and mem_addr_valid=0; mem_data_busy=1, so no data is accepted without an owner.
  - If any req*_addr_valid=1: pick the winner, set owner, go to BURST next cycle.
  - Grant latency is 1 cycle; the first address beat can transfer in the first BURST cycle.
- BURST, owner side:
  - mem_addr_valid = owner_addr_valid && !addr_done.
  - mem_addr_data = owner addr (zero for the non-owner mux leg).
  - owner_addr_busy = mem_addr_busy || addr_done.
  - non-owner addr_busy=1, data_valid=0, data_data=0.
- BURST, counters:
  - Each mem address transfer increments addr_cnt. On the transfer at addr_cnt = 2**BURST_LEN_WIDTH-1, set addr_done=1 and wrap addr_cnt to 0.
  - Extra owner address beats stay blocked until the burst ends.
- BURST, data path:
  - owner_data_valid = mem_data_valid, owner_data_data = mem_data_data, mem_data_busy = owner_data_busy.
  - Data may return before all address beats are sent (pipelined memory).
  - Each data transfer increments data_cnt.
  - The transfer at data_cnt = 2**BURST_LEN_WIDTH-1 ends the burst: next cycle is IDLE, counters and addr_done clear, owner=00.
- Boundary cases:
  - Last data beat with pending requests: one IDLE bubble cycle, then re-arbitrate.
  - Address and data transfers in the same cycle: both counters update.
  - Owner drops addr_valid mid-burst: legal, burst stays locked.
  - A memory data beat arriving before any address beat is still counted. Memory ordering is the memory's responsibility.
- Arithmetic: both counters are BURST_LEN_WIDTH wide, unsigned, and wrap modulo 2**BURST_LEN_WIDTH.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit rr pointer updates at burst end to favour the requester that did not own the burst. On simultaneous requests in IDLE, the favoured one wins.
- Undefined: fixed priority, req0 always wins simultaneous requests; no pointer register.

Decomposition:
- Shared package: state encodings (IDLE, BURST), owner one-hot constants (OWN_NONE, OWN_REQ0, OWN_REQ1), burst length derivation from BURST_LEN_WIDTH.
- One sub-module, arb_burst_counter: BURST_LEN_WIDTH-wide counter with increment enable, synchronous clear, and a last-beat flag. Instantiated twice (address and data).

Test Plan:
- Reset then idle with all inputs 0 -> arb_owner=00, req*_addr_busy=1, mem_data_busy=1, all valids 0.
- req1 alone requests base 0x0000_1000, memory never busy -> arb_owner=10 from cycle 1. 16 addresses forwarded 0x1000..0x1078 (step 8); 16 data beats on req1 only; then IDLE.
- req0 and req1 request in the same cycle, two bursts back-to-back -> fixed priority: req0 is granted both times. With MEM_ARB_ROUND_ROBIN_EN: req0, then req1.
- mem_addr_busy toggled every other cycle and req0_data_busy asserted for 3 cycles mid-burst -> no beat lost or duplicated; mem_data_busy follows req0_data_busy; exactly 16 beats each way.
- rst asserted after 5 data beats -> next cycle IDLE, counters 0. A new req1 burst completes with a full 16 beats.
- Owner keeps addr_valid high after its 16th address beat -> req_addr_busy=1 and no 17th mem_addr_valid beat.
